// File: rtl/simple_bus_arbiter.sv
// Two-master round-robin arbiter onto one register-bus slave, one transaction in flight.
// Define SIMPLE_BUS_ARB_TIMEOUT_EN to add a WAIT watchdog that completes stalled accesses with ERR.
module simple_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WRDAT,
  input  logic          M0_WR,
  input  logic          M0_RD,
  output logic          M0_WRREADY,
  output logic          M0_RDREADY,
  output logic [DW-1:0] M0_RDDAT,
  output logic          M0_ERR,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WRDAT,
  input  logic          M1_WR,
  input  logic          M1_RD,
  output logic          M1_WRREADY,
  output logic          M1_RDREADY,
  output logic [DW-1:0] M1_RDDAT,
  output logic          M1_ERR,
  output logic [AW-1:0] S_ADDR,
  output logic [DW-1:0] S_WRDAT,
  output logic          S_WR,
  output logic          S_RD,
  input  logic          S_WRREADY,
  input  logic          S_RDREADY,
  input  logic [DW-1:0] S_RDDAT,
  output logic [1:0]    GRANT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        r_state, w_next;
  logic          r_owner;   // 0 = M0, 1 = M1
  logic          r_last;    // master granted last
  logic          r_is_wr;
  logic [AW-1:0] r_saddr;
  logic [DW-1:0] r_swrdat;
  logic [DW-1:0] r_rddat0, r_rddat1;
  logic          r_err;

  logic          w_req0, w_req1, w_any, w_win, w_win_wr;
  logic          w_match, w_expire, w_done;
  logic [DW-1:0] w_rd_load;

  assign w_req0   = M0_WR | M0_RD;
  assign w_req1   = M1_WR | M1_RD;
  assign w_any    = w_req0 | w_req1;
  assign w_win    = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_win_wr = w_win ? M1_WR : M0_WR;   // WR beats RD from the same master
  assign w_match  = r_is_wr ? S_WRREADY : S_RDREADY;
  assign w_done   = (r_state == WAIT) & (w_match | w_expire);

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [31:0]   C_DEAD   = 32'hDEADBEEF;
  logic [CW-1:0] r_cnt;

  assign w_expire  = (r_cnt == CW'(TIMEOUT - 1));
  // A genuine ready in the expiry cycle wins over the watchdog.
  assign w_rd_load = w_match ? S_RDDAT : DW'(C_DEAD);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      else                 r_cnt <= '0;
      if (w_done)          r_err <= ~w_match;
    end
  end
`else
  assign w_expire  = 1'b0;
  assign w_rd_load = S_RDDAT;
  assign r_err     = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    if (w_match | w_expire) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_is_wr  <= 1'b0;
      r_saddr  <= '0;
      r_swrdat <= '0;
      r_rddat0 <= '0;
      r_rddat1 <= '0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_owner  <= w_win;
        r_is_wr  <= w_win_wr;
        r_saddr  <= w_win ? M1_ADDR  : M0_ADDR;
        r_swrdat <= w_win ? M1_WRDAT : M0_WRDAT;
      end
      if (w_done) begin
        r_last <= r_owner;
        if (!r_is_wr) begin
          if (r_owner) r_rddat1 <= w_rd_load;
          else         r_rddat0 <= w_rd_load;
        end
      end
    end
  end

  // GRANT stays up through RESP so the master sees its ready before re-arbitration.
  assign GRANT   = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);
  assign S_ADDR  = r_saddr;
  assign S_WRDAT = r_swrdat;
  assign S_WR    = (r_state == ISSUE) &  r_is_wr;
  assign S_RD    = (r_state == ISSUE) & ~r_is_wr;

  assign M0_WRREADY = (r_state == RESP) & ~r_owner &  r_is_wr;
  assign M0_RDREADY = (r_state == RESP) & ~r_owner & ~r_is_wr;
  assign M1_WRREADY = (r_state == RESP) &  r_owner &  r_is_wr;
  assign M1_RDREADY = (r_state == RESP) &  r_owner & ~r_is_wr;
  assign M0_ERR     = (r_state == RESP) & ~r_owner & r_err;
  assign M1_ERR     = (r_state == RESP) &  r_owner & r_err;
  assign M0_RDDAT   = r_rddat0;
  assign M1_RDDAT   = r_rddat1;

endmodule

// File: tb/tb_simple_bus_arbiter.sv
// Scoreboard bench for simple_bus_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops them whenever the DUT strobes the slave or completes to a master.
module tb_simple_bus_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] M0_ADDR, M0_WRDAT, M1_ADDR, M1_WRDAT;
  logic        M0_WR, M0_RD, M1_WR, M1_RD;
  logic        M0_WRREADY, M0_RDREADY, M1_WRREADY, M1_RDREADY, M0_ERR, M1_ERR;
  logic [31:0] M0_RDDAT, M1_RDDAT, S_ADDR, S_WRDAT;
  logic        S_WR, S_RD;
  logic        S_WRREADY = 1'b0;
  logic        S_RDREADY = 1'b0;
  logic [31:0] S_RDDAT   = '0;
  logic [1:0]  GRANT;

  simple_bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_ADDR(M0_ADDR), .M0_WRDAT(M0_WRDAT), .M0_WR(M0_WR), .M0_RD(M0_RD),
    .M0_WRREADY(M0_WRREADY), .M0_RDREADY(M0_RDREADY), .M0_RDDAT(M0_RDDAT), .M0_ERR(M0_ERR),
    .M1_ADDR(M1_ADDR), .M1_WRDAT(M1_WRDAT), .M1_WR(M1_WR), .M1_RD(M1_RD),
    .M1_WRREADY(M1_WRREADY), .M1_RDREADY(M1_RDREADY), .M1_RDDAT(M1_RDDAT), .M1_ERR(M1_ERR),
    .S_ADDR(S_ADDR), .S_WRDAT(S_WRDAT), .S_WR(S_WR), .S_RD(S_RD),
    .S_WRREADY(S_WRREADY), .S_RDREADY(S_RDREADY), .S_RDDAT(S_RDDAT), .GRANT(GRANT)
  );

  always #5 ACLK = ~ACLK;

  typedef struct { int m; bit wr; logic [31:0] addr; logic [31:0] data; } s_exp_t;
  typedef struct { int m; bit wr; logic [31:0] rd; bit err; } m_exp_t;

  s_exp_t sq[$];
  m_exp_t mq[$];
  int     n_tests = 0;
  int     n_fail  = 0;

  // slave model knobs: mode 0 normal, 1 silent, 2 wrong-type ready first
  int          sl_mode = 0;
  int          sl_lat  = 1;
  logic [31:0] sl_data = '0;
  bit          sl_wr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push_exp(input int m, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rd, input bit err);
    sq.push_back('{m, wr, addr, data});
    mq.push_back('{m, wr, rd, err});
  endtask

  task automatic m_xfer(input int m, input bit wr, input logic [31:0] addr, input logic [31:0] data);
    bit got = 0;
    if (m == 0) begin M0_ADDR = addr; M0_WRDAT = data; M0_WR = wr; M0_RD = !wr; end
    else        begin M1_ADDR = addr; M1_WRDAT = data; M1_WR = wr; M1_RD = !wr; end
    for (int i = 0; i < 300; i++) begin
      @(negedge ACLK);
      if (m == 0 ? (M0_WRREADY | M0_RDREADY) : (M1_WRREADY | M1_RDREADY)) begin got = 1; break; end
    end
    chk("xfer_done", 64'(got), 64'd1);
    cyc();
    if (m == 0) begin M0_WR = 0; M0_RD = 0; end
    else        begin M1_WR = 0; M1_RD = 0; end
  endtask

  task automatic wait_strobe(input string name);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge ACLK);
      if (S_WR || S_RD) begin ok = 1; break; end
    end
    chk(name, 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    cyc(); cyc();
    ARESET = 1'b0;
    cyc();
  endtask

  // slave responder
  always begin
    @(negedge ACLK);
    if ((S_WR || S_RD) && sl_mode != 1) begin
      sl_wr = S_WR;
      repeat (sl_lat) @(posedge ACLK);
      #1;
      if (sl_mode == 2) begin
        S_WRREADY = !sl_wr; S_RDREADY = sl_wr; S_RDDAT = '0;
        cyc();
        S_WRREADY = 1'b0; S_RDREADY = 1'b0;
        cyc();
      end
      S_WRREADY = sl_wr; S_RDREADY = !sl_wr; S_RDDAT = sl_wr ? 32'h0 : sl_data;
      cyc();
      S_WRREADY = 1'b0; S_RDREADY = 1'b0;
    end
  end

  // monitor
  s_exp_t     se;
  m_exp_t     me;
  logic [3:0] rdy;
  always @(negedge ACLK) begin
    if (S_WR || S_RD) begin
      if (sq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL strobe_unexpected: S_WR=%0b S_RD=%0b addr=%0h, required no strobe", S_WR, S_RD, S_ADDR);
      end else begin
        se = sq.pop_front();
        chk("strobe_type", 64'({S_WR, S_RD}), se.wr ? 64'd2 : 64'd1);
        chk("strobe_addr", 64'(S_ADDR), 64'(se.addr));
        if (se.wr) chk("strobe_wrdat", 64'(S_WRDAT), 64'(se.data));
        chk("strobe_grant", 64'(GRANT), (se.m == 1) ? 64'd2 : 64'd1);
      end
    end
    rdy = {M1_RDREADY, M1_WRREADY, M0_RDREADY, M0_WRREADY};
    if (rdy != 4'b0) begin
      if (mq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ready_unexpected: ready=%b, required none", rdy);
      end else begin
        me = mq.pop_front();
        chk("ready_vec", 64'(rdy), 64'(1) << (me.m * 2 + (me.wr ? 0 : 1)));
        chk("ready_err", 64'({M1_ERR, M0_ERR}), me.err ? ((me.m == 1) ? 64'd2 : 64'd1) : 64'd0);
        if (!me.wr) chk("ready_rddat", 64'((me.m == 1) ? M1_RDDAT : M0_RDDAT), 64'(me.rd));
      end
    end else if (M0_ERR || M1_ERR) begin
      n_tests++; n_fail++;
      $display("FAIL err_stray: err=%b without ready, required 00", {M1_ERR, M0_ERR});
    end
  end

  int lat;
  int cnt;
  initial begin
    ARESET = 1'b1;
    M0_ADDR = '0; M0_WRDAT = '0; M0_WR = 0; M0_RD = 0;
    M1_ADDR = '0; M1_WRDAT = '0; M1_WR = 0; M1_RD = 0;
    cyc(); cyc(); cyc();
    chk("rst_grant",   64'(GRANT), 64'd0);
    chk("rst_strobe",  64'({S_WR, S_RD}), 64'd0);
    chk("rst_saddr",   64'(S_ADDR), 64'd0);
    chk("rst_swrdat",  64'(S_WRDAT), 64'd0);
    chk("rst_rddat0",  64'(M0_RDDAT), 64'd0);
    chk("rst_rddat1",  64'(M1_RDDAT), 64'd0);
    chk("rst_ready",   64'({M1_RDREADY, M1_WRREADY, M0_RDREADY, M0_WRREADY}), 64'd0);
    chk("rst_err",     64'({M1_ERR, M0_ERR}), 64'd0);
    ARESET = 1'b0;
    cyc();

    // single write from M0, slave ready 3 cycles after S_WR
    sl_lat = 3;
    push_exp(0, 1, 32'h40, 32'h12345678, 32'h0, 0);
    m_xfer(0, 1, 32'h40, 32'h12345678);
    chk("wr_grant_idle", 64'(GRANT), 64'd0);

    // single read from M1, data held afterwards
    sl_lat = 2; sl_data = 32'hCAFEF00D;
    push_exp(1, 0, 32'h80, 32'h0, 32'hCAFEF00D, 0);
    m_xfer(1, 0, 32'h80, 32'h0);
    cyc(); cyc(); cyc();
    chk("rd_hold1", 64'(M1_RDDAT), 64'hCAFEF00D);
    chk("rd_hold0", 64'(M0_RDDAT), 64'd0);

    // both masters from reset, minimum slave latency: M0, M1, M0, M1
    do_reset();
    sl_lat = 1; sl_data = 32'h5555AAAA;
    push_exp(0, 1, 32'h100, 32'hA0, 32'h0, 0);
    push_exp(1, 1, 32'h200, 32'hB1, 32'h0, 0);
    push_exp(0, 0, 32'h104, 32'h0, 32'h5555AAAA, 0);
    push_exp(1, 0, 32'h204, 32'h0, 32'h5555AAAA, 0);
    fork
      begin m_xfer(0, 1, 32'h100, 32'hA0); m_xfer(0, 0, 32'h104, 32'h0); end
      begin m_xfer(1, 1, 32'h200, 32'hB1); m_xfer(1, 0, 32'h204, 32'h0); end
    join
    chk("rr_grant_idle", 64'(GRANT), 64'd0);

    // pending read sees S_WRREADY first (with zero data), completes only on S_RDREADY
    sl_mode = 2; sl_lat = 2; sl_data = 32'h13579BDF;
    push_exp(0, 0, 32'h44, 32'h0, 32'h13579BDF, 0);
    m_xfer(0, 0, 32'h44, 32'h0);
    sl_mode = 0;

    // reset during WAIT, slave answers after release
    sl_lat = 6;
    sq.push_back('{0, 1'b0, 32'h88, 32'h0});
    M0_ADDR = 32'h88; M0_RD = 1;
    wait_strobe("rstw_strobe");
    cyc(); cyc();
    ARESET = 1'b1; M0_RD = 0;
    cyc();
    chk("rstw_grant",  64'(GRANT), 64'd0);
    chk("rstw_saddr",  64'(S_ADDR), 64'd0);
    chk("rstw_rddat0", 64'(M0_RDDAT), 64'd0);
    chk("rstw_rddat1", 64'(M1_RDDAT), 64'd0);
    ARESET = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      if (M0_WRREADY | M0_RDREADY | M1_WRREADY | M1_RDREADY | (GRANT != 2'b00)) cnt++;
    end
    chk("rstw_quiet", 64'(cnt), 64'd0);

    // silent slave
    cyc();
    sl_mode = 1;
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    push_exp(0, 0, 32'h90, 32'h0, 32'hDEADBEEF, 1);
    M0_ADDR = 32'h90; M0_RD = 1;
    wait_strobe("to_strobe");
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ACLK);
      if (M0_RDREADY) begin lat = k; break; end
    end
    chk("to_latency", 64'(lat), 64'd9);
    cyc();
    M0_RD = 0;
    cyc(); cyc();
    chk("to_rddat_hold", 64'(M0_RDDAT), 64'hDEADBEEF);
`else
    sq.push_back('{0, 1'b0, 32'h90, 32'h0});
    M0_ADDR = 32'h90; M0_RD = 1;
    wait_strobe("nto_strobe");
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge ACLK);
      if (M0_WRREADY | M0_RDREADY | M1_WRREADY | M1_RDREADY) cnt++;
    end
    chk("nto_no_completion", 64'(cnt), 64'd0);
    chk("nto_still_granted", 64'(GRANT), 64'd1);
    cyc();
    M0_RD = 0;
    do_reset();
`endif
    sl_mode = 0;

    chk("sq_drained", 64'(sq.size()), 64'd0);
    chk("mq_drained", 64'(mq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
